// File: rtl/rv32i_types.sv
// Shared datapath types for the result-broadcast path: FU result payload,
// CDB lane contents, and the default arbiter sizing for top-level use.
package rv32i_types;

    localparam int CDB_NUM_FU  = 4;
    localparam int CDB_NUM_CDB = 2;

    typedef struct packed {
        logic [5:0]  pd_s;
        logic [4:0]  rob_num;
        logic [31:0] pd_v;
        logic [31:0] rvfi_data;
        logic        br_en;
        logic [31:0] instr_pc;
        logic        instr_is_br;
        logic        br_taken;
        logic [31:0] br_target;
    } fu_cdb_data_t;

    typedef struct packed {
        logic        valid;
        logic [5:0]  pd_s;
        logic [4:0]  rob_num;
        logic [31:0] pd_v;
        logic [31:0] rvfi_data;
        logic        br_en;
        logic [31:0] instr_pc;
        logic        instr_is_br;
        logic        br_taken;
        logic [31:0] branch_pc;
    } cdb_t;

endpackage

// File: rtl/cdb_arb_multi_rr_multi_pick.sv
// Circular priority picker: starting at start_ptr, walks the request vector
// upward (with wrap) and hands the first NUM_CDB requesters to lanes 0..NUM_CDB-1.
// next_ptr points one past the last requester picked.
module rr_multi_pick #(
    parameter int NUM_FU  = 4,
    parameter int NUM_CDB = 2,
    parameter int PW      = $clog2(NUM_FU)
) (
    input  logic [NUM_FU-1:0]  req,
    input  logic [PW-1:0]      start_ptr,
    output logic [NUM_FU-1:0]  grant_mask,
    output logic [NUM_CDB-1:0] lane_valid,
    output logic [PW-1:0]      lane_idx [NUM_CDB],
    output logic [PW-1:0]      next_ptr
);

    // Scan every FU once in circular order, filling lanes in scan order.
    always_comb begin
        logic [PW:0]   pos;
        logic [PW-1:0] idx;
        int            taken;
        grant_mask = '0;
        lane_valid = '0;
        next_ptr   = start_ptr;
        taken      = 0;
        pos        = '0;
        idx        = '0;
        for (int k = 0; k < NUM_CDB; k++) begin
            lane_idx[k] = '0;
        end
        for (int off = 0; off < NUM_FU; off++) begin
            // Explicit wrap so non-power-of-two FU counts stay in range.
            pos = {1'b0, start_ptr} + (PW+1)'(off);
            if (pos >= (PW+1)'(NUM_FU)) begin
                pos = pos - (PW+1)'(NUM_FU);
            end
            idx = pos[PW-1:0];
            if (req[idx] && (taken < NUM_CDB)) begin
                grant_mask[idx] = 1'b1;
                for (int k = 0; k < NUM_CDB; k++) begin
                    if (taken == k) begin
                        lane_valid[k] = 1'b1;
                        lane_idx[k]   = idx;
                    end
                end
                next_ptr = (pos == (PW+1)'(NUM_FU-1)) ? '0 : idx + PW'(1);
                taken++;
            end
        end
    end

endmodule

// File: rtl/cdb_arb_multi.sv
// Multi-lane CDB arbiter: grants up to NUM_CDB ready FUs per cycle in
// round-robin order, acks them combinationally, and registers their results
// onto the broadcast lanes for exactly one cycle.
module cdb_arb_multi
    import rv32i_types::*;
#(
    parameter int NUM_FU  = CDB_NUM_FU,
    parameter int NUM_CDB = CDB_NUM_CDB
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [NUM_FU-1:0] fu_done,
    input  fu_cdb_data_t      fu_output_data [NUM_FU],
    output cdb_t              cdb [NUM_CDB],
    output logic [NUM_FU-1:0] ack
);

    localparam int PW = $clog2(NUM_FU);

    logic [PW-1:0]      rr_ptr_reg;
    logic [PW-1:0]      rr_ptr_next;
    logic [PW-1:0]      pick_next_ptr;
    logic [NUM_FU-1:0]  pick_grant;
    logic [NUM_CDB-1:0] pick_lane_valid;
    logic [PW-1:0]      pick_lane_idx [NUM_CDB];
    logic               grant_en;

    rr_multi_pick #(
        .NUM_FU  (NUM_FU),
        .NUM_CDB (NUM_CDB),
        .PW      (PW)
    ) u_pick (
        .req        (fu_done),
        .start_ptr  (rr_ptr_reg),
        .grant_mask (pick_grant),
        .lane_valid (pick_lane_valid),
        .lane_idx   (pick_lane_idx),
        .next_ptr   (pick_next_ptr)
    );

    // Nothing is granted while in reset or during a flush.
    assign grant_en = rst && !flush;
    assign ack      = grant_en ? pick_grant : '0;

    // Pointer advances only when at least one FU was actually granted.
    always_comb begin
        rr_ptr_next = rr_ptr_reg;
        if (grant_en && (|pick_lane_valid)) begin
            rr_ptr_next = pick_next_ptr;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr_reg <= '0;
        end else begin
            rr_ptr_reg <= rr_ptr_next;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_CDB; gi++) begin : g_lane
            fu_cdb_data_t src;
            cdb_t         lane_next;
            cdb_t         lane_reg;

            assign src = fu_output_data[pick_lane_idx[gi]];

            // Build the lane image; idle lanes are all-zero so br_en stays low.
            always_comb begin
                lane_next = '0;
                if (grant_en && pick_lane_valid[gi]) begin
                    lane_next.valid       = 1'b1;
                    lane_next.pd_s        = src.pd_s;
                    lane_next.rob_num     = src.rob_num;
                    lane_next.pd_v        = src.pd_v;
                    lane_next.rvfi_data   = src.rvfi_data;
                    lane_next.br_en       = src.br_en;
                    lane_next.instr_pc    = src.instr_pc;
                    lane_next.instr_is_br = src.instr_is_br;
                    lane_next.br_taken    = src.br_taken;
                    lane_next.branch_pc   = src.br_target;
                end
            end

            // Lane register: one-cycle broadcast per grant, cleared on reset.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    lane_reg <= '0;
                end else begin
                    lane_reg <= lane_next;
                end
            end

            assign cdb[gi] = lane_reg;
        end
    endgenerate

endmodule
